// File: rtl/noise_env_pkg.sv
// Shared types and arithmetic helpers for the noise envelope generator.
package noise_env_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } env_state_t;

    // Full scale for a loud trigger, half scale (minus one) for a quiet one.
    function automatic logic [31:0] start_level(input logic loud, input int unsigned amp_w);
        logic [31:0] lvl;
        if (loud) begin
            lvl = (32'd1 << amp_w) - 32'd1;
        end else begin
            lvl = (32'd1 << (amp_w - 32'd1)) - 32'd1;
        end
        return lvl;
    endfunction

    // Exponential step; a minimum of one keeps the tail from stalling above zero.
    function automatic logic [31:0] decay_decrement(input logic [31:0] amp, input int unsigned shift);
        logic [31:0] d;
        d = amp >> shift;
        if ((d == 32'd0) && (amp != 32'd0)) begin
            d = 32'd1;
        end else begin
            d = d;
        end
        return d;
    endfunction

endpackage

// File: rtl/env_prescaler.sv
// Tick-gated modulo counter; step pulses on the tick that wraps the count.
module env_prescaler #(
    parameter int unsigned MODULUS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic run,
    input  logic clr,
    output logic step
);

    localparam int unsigned CNT_W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(MODULUS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tc_s;

    assign tc_s = run & clk_en & (count_q == TERMINAL);
    assign step = tc_s & ~clr;

    // Next count: clear dominates, otherwise advance and wrap on ticks while running.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (run & clk_en) begin
            if (count_q == TERMINAL) begin
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/noise_envelope.sv
// Hold-then-exponential-decay envelope applied to a 1-bit noise stream.
module noise_envelope #(
    parameter int unsigned AMP_W       = 8,
    parameter int unsigned HOLD_TICKS  = 64,
    parameter int unsigned DECAY_DIV   = 256,
    parameter int unsigned DECAY_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             sound_enable,
    input  logic             noise,
    input  logic             trigger,
    input  logic             loud,
    output logic [AMP_W-1:0] sample,
    output logic             active
);

    import noise_env_pkg::*;

    env_state_t       state_q;
    env_state_t       state_d;
    logic [AMP_W-1:0] amp_q;
    logic [AMP_W-1:0] amp_d;
    logic [AMP_W-1:0] sample_q;
    logic [AMP_W-1:0] sample_d;

    logic             load_s;
    logic             hold_step_s;
    logic             decay_step_s;
    logic             hold_clr_s;
    logic             decay_clr_s;
    logic [AMP_W-1:0] start_lvl_s;
    logic [AMP_W-1:0] dec_s;
    logic [AMP_W-1:0] amp_next_s;

    assign load_s      = trigger & sound_enable;
    assign start_lvl_s = AMP_W'(start_level(loud, AMP_W));
    assign dec_s       = AMP_W'(decay_decrement(32'(amp_q), DECAY_SHIFT));
    assign amp_next_s  = amp_q - dec_s;

    // Disabling sound also resets both counters so a later trigger starts clean.
    assign hold_clr_s  = load_s | ~sound_enable;
    assign decay_clr_s = load_s | hold_step_s | ~sound_enable;

    env_prescaler #(.MODULUS(HOLD_TICKS)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .run    (state_q == ST_HOLD),
        .clr    (hold_clr_s),
        .step   (hold_step_s)
    );

    env_prescaler #(.MODULUS(DECAY_DIV)) u_decay (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .run    (state_q == ST_DECAY),
        .clr    (decay_clr_s),
        .step   (decay_step_s)
    );

    // Envelope state and amplitude; a trigger outranks hold expiry and decay steps.
    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        if (!sound_enable) begin
            state_d = ST_IDLE;
            amp_d   = {AMP_W{1'b0}};
        end else if (load_s) begin
            state_d = ST_HOLD;
            amp_d   = start_lvl_s;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                    amp_d   = {AMP_W{1'b0}};
                end
                ST_HOLD: begin
                    if (hold_step_s) begin
                        state_d = ST_DECAY;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DECAY: begin
                    if (decay_step_s) begin
                        amp_d = amp_next_s;
                        if (amp_next_s == {AMP_W{1'b0}}) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DECAY;
                        end
                    end else begin
                        state_d = ST_DECAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    amp_d   = {AMP_W{1'b0}};
                end
            endcase
        end
    end

    // Output sample uses the amplitude held before this cycle's update.
    always_comb begin
        sample_d = sample_q;
        if (clk_en) begin
            if (noise & sound_enable) begin
                sample_d = amp_q;
            end else begin
                sample_d = {AMP_W{1'b0}};
            end
        end else begin
            sample_d = sample_q;
        end
    end

    // State, amplitude and sample registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            amp_q    <= {AMP_W{1'b0}};
            sample_q <= {AMP_W{1'b0}};
        end else begin
            state_q  <= state_d;
            amp_q    <= amp_d;
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;
    assign active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noise_envelope.sv
// Directed bench for noise_envelope with HOLD_TICKS=4, DECAY_DIV=2.
module tb_noise_envelope;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       sound_enable;
    logic       noise;
    logic       trigger;
    logic       loud;
    logic [7:0] sample;
    logic       active;

    int checks = 0;
    int errors = 0;

    // Hand-computed decay sequence from 255 with shift 3 and minimum step 1.
    int decay_seq [38] = '{224, 196, 172, 151, 133, 117, 103, 91, 80, 70, 62, 55, 49,
                           43, 38, 34, 30, 27, 24, 21, 19, 17, 15, 14, 13, 12, 11, 10,
                           9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    noise_envelope #(
        .AMP_W       (8),
        .HOLD_TICKS  (4),
        .DECAY_DIV   (2),
        .DECAY_SHIFT (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .sound_enable (sound_enable),
        .noise        (noise),
        .trigger      (trigger),
        .loud         (loud),
        .sample       (sample),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clk_en = 1'b1; sound_enable = 1'b1; noise = 1'b1;
        trigger = 1'b0; loud = 1'b1;
        clk_step();
        clk_step();
        checks++;
        if (sample !== 8'd0) begin
            errors++; $display("FAIL reset_sample got %0d exp 0", sample);
        end
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL reset_active got %b exp 0", active);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            checks++;
            if (sample !== 8'd0 || active !== 1'b0) begin
                errors++; $display("FAIL idle_quiet cyc %0d sample %0d active %b exp 0/0", i, sample, active);
            end
        end
    endtask

    task automatic test_loud_envelope();
        logic [7:0] exp_s;
        logic       exp_a;
        int         k;
        noise = 1'b1; loud = 1'b1; trigger = 1'b1;
        for (int n = 1; n <= 84; n++) begin
            clk_step();
            trigger = 1'b0;
            if (n == 1) begin
                exp_s = 8'd0;
            end else if (n < 8) begin
                exp_s = 8'd255;
            end else begin
                k = (n - 8) / 2;
                exp_s = (k < 38) ? 8'(decay_seq[k]) : 8'd0;
            end
            exp_a = (n < 81);
            checks++;
            if (sample !== exp_s || active !== exp_a) begin
                errors++;
                $display("FAIL loud_env edge %0d sample %0d active %b exp %0d/%b", n, sample, active, exp_s, exp_a);
            end
        end
    endtask

    task automatic test_quiet_gating();
        logic [7:0] exp_s;
        noise = 1'b1; loud = 1'b0; trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        for (int n = 2; n <= 7; n++) begin
            noise = n[0];
            clk_step();
            exp_s = n[0] ? 8'd127 : 8'd0;
            checks++;
            if (sample !== exp_s || active !== 1'b1) begin
                errors++;
                $display("FAIL quiet_gate edge %0d sample %0d active %b exp %0d/1", n, sample, active, exp_s);
            end
        end
    endtask

    task automatic test_retrigger();
        noise = 1'b1; loud = 1'b1; trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        for (int n = 2; n <= 13; n++) clk_step();
        checks++;
        if (sample !== 8'd172) begin
            errors++; $display("FAIL pre_retrig sample %0d exp 172", sample);
        end
        trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        clk_step();
        checks++;
        if (sample !== 8'd255 || active !== 1'b1) begin
            errors++; $display("FAIL retrig_reload sample %0d active %b exp 255/1", sample, active);
        end
        for (int n = 16; n <= 19; n++) clk_step();
        trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        clk_step();
        checks++;
        if (sample !== 8'd255) begin
            errors++; $display("FAIL trig_vs_step sample %0d exp 255", sample);
        end
        for (int n = 22; n <= 26; n++) clk_step();
        checks++;
        if (sample !== 8'd255) begin
            errors++; $display("FAIL rehold_end sample %0d exp 255", sample);
        end
        clk_step();
        checks++;
        if (sample !== 8'd224) begin
            errors++; $display("FAIL rehold_first_step sample %0d exp 224", sample);
        end
    endtask

    task automatic test_disable();
        noise = 1'b1; loud = 1'b1; trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        clk_step();
        clk_step();
        sound_enable = 1'b0;
        clk_step();
        checks++;
        if (sample !== 8'd0 || active !== 1'b0) begin
            errors++; $display("FAIL disable sample %0d active %b exp 0/0", sample, active);
        end
        trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++;
            if (sample !== 8'd0 || active !== 1'b0) begin
                errors++; $display("FAIL trig_ignored cyc %0d sample %0d active %b exp 0/0", i, sample, active);
            end
        end
        sound_enable = 1'b1;
        clk_step();
        clk_step();
    endtask

    task automatic test_gated_clock();
        logic [7:0] exp_s;
        noise = 1'b1; loud = 1'b1; clk_en = 1'b0; trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        checks++;
        if (active !== 1'b1 || sample !== 8'd0) begin
            errors++; $display("FAIL gated_trig active %b sample %0d exp 1/0", active, sample);
        end
        for (int c = 1; c <= 28; c++) begin
            clk_en = ((c % 4) == 0);
            clk_step();
            exp_s = (c < 4) ? 8'd0 : ((c < 28) ? 8'd255 : 8'd224);
            checks++;
            if (sample !== exp_s || active !== 1'b1) begin
                errors++;
                $display("FAIL gated cyc %0d sample %0d active %b exp %0d/1", c, sample, active, exp_s);
            end
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        noise = 1'b1; loud = 1'b1; trigger = 1'b1;
        clk_step();
        trigger = 1'b0;
        clk_step();
        clk_step();
        rst = 1'b0;
        clk_step();
        checks++;
        if (sample !== 8'd0 || active !== 1'b0) begin
            errors++; $display("FAIL reset_mid sample %0d active %b exp 0/0", sample, active);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_step();
            checks++;
            if (sample !== 8'd0 || active !== 1'b0) begin
                errors++; $display("FAIL post_reset cyc %0d sample %0d active %b exp 0/0", i, sample, active);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loud_envelope();
        test_quiet_gating();
        test_retrigger();
        test_disable();
        test_gated_clock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
